// File: rtl/lfsr_hash_checker.sv
// Receive-side keyed byte-hash checker: regenerates the expected tag stream from
// the session seed and compares it pair by pair against the received tags.
//
//   state  | meaning
//   IDLE   | waiting for start; counters hold last session's values
//   RUN    | accepting (data, tag) pairs and checking them
//   REPORT | session summary on done/pass until ack
module lfsr_hash_checker #(
    parameter int CNT_W         = 16,
    parameter bit STOP_ON_ERROR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [31:0]      in_hash,
    input  logic             in_last,
    output logic             chk_valid,
    output logic             chk_match,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] byte_count,
    output logic [CNT_W-1:0] err_count,
    input  logic             ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    // ROW[0] occupies the most significant byte.
    localparam logic [255:0] ROWS =
        256'hA53CF7921E4D8B6AC35FE8B17D2A9C4EF28D6BC45AE9B27E2B9D4FF38E6CC55B;

    state_t      state, state_nxt;
    logic [31:0] lfsr_l, lfsr_m;
    logic [31:0] exp_hash;
    logic        xfer;
    logic        mismatch;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    function automatic logic [31:0] toeplitz(input logic [7:0] d);
        logic [31:0] t;
        t = '0;
        for (int i = 0; i < 32; i++) begin
            t[i] = ^(ROWS[255 - 8*i -: 8] & d);
        end
        return t;
    endfunction

    always_comb begin
        exp_hash  = toeplitz(in_data) ^ lfsr_l ^ lfsr_m;
        xfer      = in_valid && (state == RUN);
        mismatch  = (in_hash != exp_hash);
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (xfer && (in_last || (STOP_ON_ERROR && mismatch))) state_nxt = REPORT;
            end
            REPORT: begin
                if (ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lfsr_l     <= '0;
            lfsr_m     <= '1;
            byte_count <= '0;
            err_count  <= '0;
            chk_valid  <= 1'b0;
            chk_match  <= 1'b0;
        end else begin
            state     <= state_nxt;
            chk_valid <= xfer;
            chk_match <= xfer && !mismatch;
            if (state == IDLE && start) begin
                lfsr_l     <= {seed, 24'h0};
                lfsr_m     <= '1;
                byte_count <= '0;
                err_count  <= '0;
            end else if (xfer) begin
                lfsr_l <= lfsr_step(lfsr_l);
                lfsr_m <= lfsr_step(lfsr_m);
                if (byte_count != '1) byte_count <= byte_count + CNT_W'(1);
                if (mismatch && err_count != '1) err_count <= err_count + CNT_W'(1);
            end
        end
    end

    // Outputs decode the registered state only, so in_ready never sees in_valid.
    assign in_ready = (state == RUN);
    assign busy     = (state == RUN) || (state == REPORT);
    assign done     = (state == REPORT);
    assign pass     = done && (err_count == '0) && (byte_count != '0);

endmodule

// File: tb/tb_lfsr_hash_checker.sv
// Directed bench for lfsr_hash_checker: instance a runs to in_last, instance b
// stops on the first mismatch; both share the same stimulus.
module tb_lfsr_hash_checker;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_last, ack;
    logic [7:0]  seed, in_data;
    logic [31:0] in_hash;

    logic        in_ready_a, chk_valid_a, chk_match_a, busy_a, done_a, pass_a;
    logic [15:0] byte_count_a, err_count_a;
    logic        in_ready_b, chk_valid_b, chk_match_b, busy_b, done_b, pass_b;
    logic [15:0] byte_count_b, err_count_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lfsr_hash_checker #(.CNT_W(16), .STOP_ON_ERROR(1'b0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .in_hash(in_hash), .in_last(in_last), .chk_valid(chk_valid_a),
        .chk_match(chk_match_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .byte_count(byte_count_a), .err_count(err_count_a), .ack(ack)
    );

    lfsr_hash_checker #(.CNT_W(16), .STOP_ON_ERROR(1'b1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .in_hash(in_hash), .in_last(in_last), .chk_valid(chk_valid_b),
        .chk_match(chk_match_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .byte_count(byte_count_b), .err_count(err_count_b), .ack(ack)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_session(input logic [7:0] s);
        start = 1'b1;
        seed  = s;
        tick();
        start = 1'b0;
        check_val("start_ready", {31'b0, in_ready_a}, 32'd1);
    endtask

    // Present one pair for one cycle and check the result pulse of instance a.
    task automatic send_pair(input string tag, input logic [7:0] d, input logic [31:0] h,
                             input logic last, input logic exp_match);
        in_valid = 1'b1;
        in_data  = d;
        in_hash  = h;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_val({tag, "_vld"}, {31'b0, chk_valid_a}, 32'd1);
        check_val({tag, "_match"}, {31'b0, chk_match_a}, {31'b0, exp_match});
    endtask

    task automatic release_report();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_val("ack_idle", {30'b0, busy_a, done_a}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; seed = '0; in_valid = 1'b0;
        in_data = '0; in_hash = '0; in_last = 1'b0; ack = 1'b0;
        tick();
        tick();
        check_val("rst_flags", {26'b0, in_ready_a, chk_valid_a, chk_match_a, busy_a, done_a, pass_a}, 32'd0);
        check_val("rst_counts", {byte_count_a, err_count_a}, 32'd0);
        reset = 1'b0;
        tick();
        check_val("idle_ready", {31'b0, in_ready_a}, 32'd0);

        // Single pair, seed 00, data 00: expected tag is just M_0.
        begin_session(8'h00);
        send_pair("single", 8'h00, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check_val("single_done", {30'b0, done_a, pass_a}, 32'd3);
        check_val("single_cnt", {byte_count_a, err_count_a}, {16'd1, 16'd0});
        release_report();

        // Two pairs: M_1 = FFFFFFFE.
        begin_session(8'h00);
        send_pair("two0", 8'h00, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send_pair("two1", 8'h00, 32'hFFFF_FFFE, 1'b1, 1'b1);
        check_val("two_done", {30'b0, done_a, pass_a}, 32'd3);
        check_val("two_cnt", {16'b0, byte_count_a}, 32'd2);
        release_report();

        // Toeplitz column 0: T(01) = CF261B65.
        begin_session(8'h00);
        send_pair("toep", 8'h01, 32'h30D9_E49A, 1'b1, 1'b1);
        release_report();

        begin_session(8'h01);
        send_pair("seed01", 8'h00, 32'hFEFF_FFFF, 1'b1, 1'b1);
        release_report();

        // Seed 80: L_0 = 80000000, L_1 = 00000001.
        begin_session(8'h80);
        send_pair("seed80_0", 8'h00, 32'h7FFF_FFFF, 1'b0, 1'b1);
        send_pair("seed80_1", 8'h00, 32'hFFFF_FFFF, 1'b1, 1'b1);
        release_report();

        // Middle tag corrupted: a runs to last, b stops after pair 2.
        begin_session(8'h00);
        send_pair("mis0", 8'h00, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send_pair("mis1", 8'h00, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_val("mis1_a_done", {31'b0, done_a}, 32'd0);
        check_val("mis1_b_done", {31'b0, done_b}, 32'd1);
        check_val("mis1_b_vld", {30'b0, chk_valid_b, chk_match_b}, 32'd2);
        check_val("mis2_b_ready", {31'b0, in_ready_b}, 32'd0);
        send_pair("mis2", 8'h00, 32'hFFFF_FFFD, 1'b1, 1'b1);
        check_val("mis2_b_vld", {31'b0, chk_valid_b}, 32'd0);
        check_val("mis_b_cnt", {byte_count_b, err_count_b}, {16'd2, 16'd1});
        check_val("mis_b_pass", {30'b0, done_b, pass_b}, 32'd2);
        check_val("mis_a_cnt", {byte_count_a, err_count_a}, {16'd3, 16'd1});
        check_val("mis_a_pass", {30'b0, done_a, pass_a}, 32'd2);
        release_report();
        check_val("idle_hold_cnt", {byte_count_a, err_count_a}, {16'd3, 16'd1});

        // start and ack while in RUN are ignored; idle gaps don't advance L/M.
        begin_session(8'h00);
        start = 1'b1;
        seed  = 8'hFF;
        ack   = 1'b1;
        send_pair("ctl0", 8'h00, 32'hFFFF_FFFF, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        tick();
        ack = 1'b0;
        check_val("ctl_busy", {30'b0, busy_a, in_ready_a}, 32'd3);
        send_pair("gap1", 8'h01, 32'h30D9_E49B, 1'b1, 1'b1);
        check_val("gap_cnt", {byte_count_a, err_count_a}, {16'd2, 16'd0});
        release_report();

        // Reset in the middle of a session.
        begin_session(8'h00);
        send_pair("pre_rst", 8'h00, 32'hFFFF_FFFF, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_hash  = 32'hFFFF_FFFE;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_val("midrst_flags", {26'b0, in_ready_a, chk_valid_a, chk_match_a, busy_a, done_a, pass_a}, 32'd0);
        check_val("midrst_cnt", {byte_count_a, err_count_a}, 32'd0);
        tick();
        check_val("midrst_vld", {31'b0, chk_valid_a}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_hash_checker.md
Name: lfsr_hash_checker

Overview:
Receive-side counterpart of the keyed byte hasher. It consumes a stream of (data byte, 32-bit tag) pairs and regenerates the expected tag sequence from the same shared seed. Each received tag is compared against its expected value, with a per-byte match result and an end-of-session pass/fail summary. The block sits after the link receiver and ahead of the consumer that must reject tampered frames.

Parameters:
CNT_W, 16, width of the byte and error counters (both saturate at all-ones)
STOP_ON_ERROR, 0, 1 = end the session on the first mismatch; 0 = run to in_last

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin session; sampled only in IDLE
seed  in  8  session seed byte; sampled with start
in_valid  in  1  data/tag pair valid
in_ready  out  1  checker accepts a pair; high only in RUN
in_data  in  8  received data byte
in_hash  in  32  received tag for in_data
in_last  in  1  final pair of the session
chk_valid  out  1  one-cycle pulse, one cycle after each accepted pair
chk_match  out  1  result for that pair; meaningful only when chk_valid=1
busy  out  1  high in RUN and REPORT
done  out  1  high throughout REPORT
pass  out  1  in REPORT: err_count==0 and byte_count!=0
byte_count  out  CNT_W  pairs accepted this session
err_count  out  CNT_W  mismatches this session
ack  in  1  releases REPORT

Behaviour:
- Hash definition, for accepted pair k (k=0 is the first pair):
  - exp_k = T(in_data) ^ L_k ^ M_k.
  - T bit i = XOR-reduce(ROW[i] & in_data), for i=0..31.
  - ROW[0..31] = A5 3C F7 92 1E 4D 8B 6A C3 5F E8 B1 7D 2A 9C 4E F2 8D 6B C4 5A E9 B2 7E 2B 9D 4F F3 8E 6C C5 5B (hex).
  - L_0 = {seed, 24'h0}. M_0 = 32'hFFFFFFFF.
  - Both registers advance once per accepted pair: X' = {X[30:0], X[31]^X[21]^X[1]^X[0]}.
  - L and M do not advance on idle cycles.
- FSM states are IDLE, RUN and REPORT.
  - IDLE: in_ready=0. On start=1, load L={seed,24'h0}, M=FFFFFFFF, clear both counters, then go to RUN.
  - RUN: in_ready=1. A transfer occurs when in_valid & in_ready.
    - On a transfer, compare in_hash against exp_k. Next cycle, assert chk_valid=1 with chk_match = (in_hash==exp_k).
    - byte_count increments, saturating. err_count increments on mismatch, saturating.
    - Go to REPORT after the transfer if in_last=1, or if STOP_ON_ERROR=1 and the pair mismatched.
  - REPORT: in_ready=0, done=1, pass valid. Counters hold. On ack=1, go to IDLE.
- Counters hold in IDLE until the next start. done and pass are 0 outside REPORT.
- start is ignored in RUN and REPORT. ack is ignored outside REPORT.
- in_ready is a registered state decode and does not depend combinationally on in_valid.
- The chk_valid pulse for the final pair coincides with the first cycle of REPORT.
- Reset values: FSM=IDLE, in_ready=0, chk_valid=0, chk_match=0, busy=0, done=0, pass=0, byte_count=0, err_count=0, L=0, M=FFFFFFFF.
- Reset mid-session aborts the session; no chk_valid pulse is produced for a pair presented in the reset cycle.
- Back-to-back transfers are supported every cycle, giving one result per cycle.

Test Plan:
- Basic single pair: start with seed=00; send data=00, hash=FFFFFFFF, last=1.
  -> chk_valid with chk_match=1; done=1, pass=1, byte_count=1, err_count=0.
- Two-pair stream: seed=00; send data=00 hash=FFFFFFFF, then data=00 hash=FFFFFFFE (last).
  -> two matches, pass=1, byte_count=2.
- Toeplitz path and non-zero seed:
  - seed=00, data=01, hash=30D9E49A -> match.
  - New session, seed=01, data=00, hash=FEFFFFFF -> match.
- Mismatch accumulation: STOP_ON_ERROR=0; 3-pair stream with the middle tag bit-flipped.
  -> chk_match pattern 1,0,1; err_count=1, pass=0, REPORT reached only after in_last.
- Stop-on-error: STOP_ON_ERROR=1, same stream.
  -> REPORT after pair 2; in_ready=0 for pair 3; byte_count=2.
- Control edges:
  - start in RUN ignored.
  - in_valid gaps do not advance L/M; the result is unchanged versus the gapless stream.
  - reset asserted mid-RUN -> IDLE next cycle, all outputs at reset values.
  - ack held while in RUN has no effect.
